// File: rtl/qar_timer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare and level interrupt.
// Single-cycle registered bus response; MTIME_HI reads return a shadow latched on MTIME_LO reads.
module qar_timer #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0400,
    parameter logic [31:0] PRESC_RESET = 32'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        irq_timer
);
    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;
    localparam logic [2:0] OFF_PRESC    = 3'd5;

    logic        hit_c;
    logic        accept_c;
    logic        wr_c;
    logic        rd_c;
    logic [2:0]  offset_c;
    logic        unused_c;

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [31:0] shadow_q, shadow_d;
    logic [31:0] pcnt_q, pcnt_d;
    logic [31:0] presc_q, presc_d;
    logic [1:0]  ctrl_q, ctrl_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    assign unused_c = ^mem_addr[1:0];

    // Address decode; no acceptance while a response is on the bus.
    always_comb begin
        hit_c    = (mem_addr[31:5] == BASE_ADDR[31:5]);
        offset_c = mem_addr[4:2];
        accept_c = mem_valid & hit_c & ~ready_q;
        wr_c     = accept_c & mem_we;
        rd_c     = accept_c & ~mem_we;
    end

    // Timer/register next state; software MTIME writes override the tick.
    always_comb begin
        mtime_d  = mtime_q;
        pcnt_d   = pcnt_q;
        shadow_d = shadow_q;
        cmp_d    = cmp_q;
        ctrl_d   = ctrl_q;
        presc_d  = presc_q;

        if (ctrl_q[0]) begin
            if (pcnt_q == presc_q) begin
                pcnt_d  = 32'd0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                pcnt_d = pcnt_q + 32'd1;
            end
        end

        if (wr_c) begin
            case (offset_c)
                OFF_MTIME_LO: begin
                    mtime_d = {mtime_q[63:32], mem_wdata};
                    pcnt_d  = 32'd0;
                end
                OFF_MTIME_HI: begin
                    mtime_d  = {mem_wdata, mtime_q[31:0]};
                    shadow_d = mem_wdata;
                    pcnt_d   = 32'd0;
                end
                OFF_CMP_LO: cmp_d[31:0]  = mem_wdata;
                OFF_CMP_HI: cmp_d[63:32] = mem_wdata;
                OFF_CTRL:   ctrl_d       = mem_wdata[1:0];
                OFF_PRESC:  presc_d      = mem_wdata;
                default:    ;
            endcase
        end

        if (rd_c && (offset_c == OFF_MTIME_LO)) begin
            shadow_d = mtime_q[63:32];
        end
    end

    // Bus response and interrupt, evaluated on post-edge register values.
    always_comb begin
        ready_d = accept_c;
        rdata_d = 32'd0;
        if (rd_c) begin
            case (offset_c)
                OFF_MTIME_LO: rdata_d = mtime_q[31:0];
                OFF_MTIME_HI: rdata_d = shadow_q;
                OFF_CMP_LO:   rdata_d = cmp_q[31:0];
                OFF_CMP_HI:   rdata_d = cmp_q[63:32];
                OFF_CTRL:     rdata_d = {30'd0, ctrl_q};
                OFF_PRESC:    rdata_d = presc_q;
                default:      rdata_d = 32'd0;
            endcase
        end
        irq_d = ctrl_d[1] & (mtime_d >= cmp_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q  <= 64'd0;
            cmp_q    <= 64'hFFFF_FFFF_FFFF_FFFF;
            shadow_q <= 32'd0;
            pcnt_q   <= 32'd0;
            presc_q  <= PRESC_RESET;
            ctrl_q   <= 2'd0;
            ready_q  <= 1'b0;
            rdata_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            mtime_q  <= mtime_d;
            cmp_q    <= cmp_d;
            shadow_q <= shadow_d;
            pcnt_q   <= pcnt_d;
            presc_q  <= presc_d;
            ctrl_q   <= ctrl_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign irq_timer = irq_q;

endmodule

// File: tb/tb_qar_timer.sv
// Directed bench for qar_timer: bus protocol, prescaler, wrap, shadow read, irq and reset.
module tb_qar_timer;
    localparam logic [31:0] BASE = 32'h0000_0400;
    localparam logic [2:0] O_LO = 3'd0, O_HI = 3'd1, O_CLO = 3'd2, O_CHI = 3'd3,
                           O_CTRL = 3'd4, O_PRESC = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        irq_timer;

    int checks = 0;
    int errors = 0;
    logic [31:0] rv;
    int   pulses, consec;
    logic prev_rdy, any_rdy;
    logic [31:0] any_rd;

    qar_timer #(.BASE_ADDR(BASE), .PRESC_RESET(32'd0)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .irq_timer(irq_timer)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus transaction; called #1 after a rising edge, returns #1 after the ready edge.
    task automatic bus(input logic we, input logic [2:0] off, input logic [31:0] wd,
                       output logic [31:0] rd);
        logic seen;
        seen = 1'b0;
        if (mem_ready) begin
            @(posedge clk); #1;
        end
        mem_valid = 1'b1;
        mem_we    = we;
        mem_addr  = BASE | {27'd0, off, 2'b00};
        mem_wdata = wd;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (mem_ready) seen = 1'b1;
        end
        rd        = mem_rdata;
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        check("bus_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] wd);
        logic [31:0] dummy;
        bus(1'b1, off, wd, dummy);
    endtask

    task automatic rd(input logic [2:0] off, output logic [31:0] d);
        bus(1'b0, off, 32'd0, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        // Asynchronous reset before any clock edge
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_irq", {31'd0, irq_timer}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Accepted in the first clock after release
        mem_valid = 1'b1; mem_we = 1'b0; mem_addr = BASE | 32'h8;
        @(posedge clk); #1;
        check("first_clk_ready", {31'd0, mem_ready}, 32'd1);
        check("rst_cmp_lo", mem_rdata, 32'hFFFF_FFFF);
        mem_valid = 1'b0;
        rd(O_CHI, rv);   check("rst_cmp_hi", rv, 32'hFFFF_FFFF);
        rd(O_CTRL, rv);  check("rst_ctrl", rv, 32'd0);
        rd(O_PRESC, rv); check("rst_presc", rv, 32'd0);
        rd(O_LO, rv);    check("rst_mtime_lo", rv, 32'd0);

        // PRESC=0, CMP=5, CTRL=3: MTIME reaches 5 after 5 clocks, irq with it
        wr(O_PRESC, 32'd0);
        wr(O_CLO, 32'd5);
        wr(O_CHI, 32'd0);
        wr(O_CTRL, 32'd3);
        check("irq_en_edge", {31'd0, irq_timer}, 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        check("irq_at_4", {31'd0, irq_timer}, 32'd0);
        @(posedge clk); #1;
        check("irq_at_5", {31'd0, irq_timer}, 32'd1);
        rd(O_LO, rv);    check("mtime_5", rv, 32'd5);
        wr(O_CLO, 32'd1000);
        check("irq_cmp_raise", {31'd0, irq_timer}, 32'd0);
        wr(O_CLO, 32'd0);
        check("irq_cmp_zero", {31'd0, irq_timer}, 32'd1);
        wr(O_CTRL, 32'd1);
        check("irq_en_clear", {31'd0, irq_timer}, 32'd0);

        // PRESC=3, 16 enabled clocks -> +4
        wr(O_CTRL, 32'd0);
        wr(O_LO, 32'd0);
        wr(O_HI, 32'd0);
        wr(O_PRESC, 32'd3);
        wr(O_CTRL, 32'd1);
        repeat (16) begin @(posedge clk); #1; end
        rd(O_LO, rv);    check("presc3_16clk", rv, 32'd4);
        rd(O_PRESC, rv); check("presc_read", rv, 32'd3);

        // Full 64-bit wrap
        wr(O_CTRL, 32'd0);
        wr(O_PRESC, 32'd0);
        wr(O_HI, 32'hFFFF_FFFF);
        wr(O_LO, 32'hFFFF_FFFF);
        wr(O_CTRL, 32'd1);
        rd(O_LO, rv);    check("wrap_lo", rv, 32'd0);
        rd(O_HI, rv);    check("wrap_hi", rv, 32'd0);

        // LO-then-HI read across a carry stays consistent
        wr(O_CTRL, 32'd0);
        wr(O_HI, 32'd5);
        wr(O_LO, 32'hFFFF_FFFE);
        wr(O_CTRL, 32'd1);
        rd(O_LO, rv);    check("carry_lo", rv, 32'hFFFF_FFFF);
        rd(O_HI, rv);    check("carry_hi_shadow", rv, 32'd5);
        rd(O_LO, rv);    check("carry_lo2", rv, 32'd3);
        rd(O_HI, rv);    check("carry_hi2", rv, 32'd6);

        // Software MTIME writes win over a same-cycle tick
        wr(O_CTRL, 32'd0);
        wr(O_HI, 32'd7);
        wr(O_LO, 32'd0);
        wr(O_CTRL, 32'd1);
        wr(O_LO, 32'd100);
        rd(O_LO, rv);    check("lo_write_tick", rv, 32'd101);
        wr(O_HI, 32'd9);
        rd(O_LO, rv);    check("hi_write_lo_kept", rv, 32'd104);
        rd(O_HI, rv);    check("hi_write_val", rv, 32'd9);
        wr(O_CTRL, 32'd0);
        rd(O_LO, rv);    check("hold_en0", rv, 32'd109);
        rd(O_LO, rv);    check("hold_en0_again", rv, 32'd109);

        // Held mem_valid: one pulse per acceptance, never back to back
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_we = 1'b1; mem_addr = BASE | 32'h10; mem_wdata = 32'hFFFF_FFFE;
        pulses = 0; consec = 0; prev_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                pulses++;
                if (prev_rdy) consec++;
            end
            prev_rdy = mem_ready;
            if (i == 2) begin mem_valid = 1'b0; mem_we = 1'b0; end
        end
        check("held_pulses", 32'(pulses), 32'd2);
        check("held_consec", 32'(consec), 32'd0);
        rd(O_CTRL, rv);  check("ctrl_mask", rv, 32'd2);
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, rv);    check("off7_read", rv, 32'd0);
        rd(3'd6, rv);    check("off6_read", rv, 32'd0);

        // Out-of-window access is never accepted
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_we = 1'b1; mem_addr = BASE + 32'd32 + 32'h10; mem_wdata = 32'd0;
        any_rdy = 1'b0; any_rd = 32'd0;
        repeat (4) begin
            @(posedge clk); #1;
            any_rdy = any_rdy | mem_ready;
            any_rd  = any_rd | mem_rdata;
        end
        mem_valid = 1'b0; mem_we = 1'b0;
        check("miss_ready", {31'd0, any_rdy}, 32'd0);
        check("miss_rdata", any_rd, 32'd0);
        rd(O_CTRL, rv);  check("miss_no_write", rv, 32'd2);
        check("irq_cmp0_en", {31'd0, irq_timer}, 32'd1);

        // Reset mid-transaction clears outputs at once and leaves no stale ready
        @(posedge clk); #1;
        mem_valid = 1'b1; mem_we = 1'b0; mem_addr = BASE | 32'h10;
        @(posedge clk); #1;
        check("pre_rst_ready", {31'd0, mem_ready}, 32'd1);
        check("pre_rst_rdata", mem_rdata, 32'd2);
        #2 rst_n = 1'b0;
        mem_valid = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, mem_ready}, 32'd0);
        check("mid_rst_rdata", mem_rdata, 32'd0);
        check("mid_rst_irq", {31'd0, irq_timer}, 32'd0);
        #3 rst_n = 1'b1;
        any_rdy = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            any_rdy = any_rdy | mem_ready;
        end
        check("no_stale_ready", {31'd0, any_rdy}, 32'd0);
        rd(O_CTRL, rv);  check("post_rst_ctrl", rv, 32'd0);
        rd(O_LO, rv);    check("post_rst_mtime", rv, 32'd0);
        rd(O_CHI, rv);   check("post_rst_cmp_hi", rv, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
